debounce_ctrl: RTL

- Shared-timebase debounce controller for up to N_CH push-buttons/switches on the board.
- One prescaler generates a sample tick that all channels share; each channel keeps a small tick counter instead of a full-width clock counter.
- Produces per-channel debounced levels and single-cycle press/release pulses.
- A round-robin arbiter serialises edge events onto one valid/ready event port for a downstream consumer (e.g. MicroBlaze GPIO bridge or menu FSM).

---
 rtl/debounce_ctrl_if.sv | 15 +
 rtl/debounce_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/debounce_ctrl_if.sv
// Debounced edge-event port: one event (channel index + press/release kind)
// per valid/ready handshake.
interface debounce_ctrl_if #(
    parameter int N_CH = 4
);
    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic            ev_valid;
    logic            ev_ready;
    logic [CH_W-1:0] ev_ch;
    logic            ev_press;

    modport master (output ev_valid, ev_ch, ev_press, input ev_ready);
    modport slave  (input ev_valid, ev_ch, ev_press, output ev_ready);
endinterface

// File: rtl/debounce_ctrl.sv
// Shared-prescaler debouncer for N_CH buttons with a round-robin
// valid/ready event port carrying debounced press/release edges.
module debounce_lane #(
    parameter int STABLE_TICKS = 10,
    parameter int CNT_W        = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    input  logic tick,
    output logic o,
    output logic press,
    output logic rel
);
    logic             s1, s2;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            cnt   <= '0;
            o     <= 1'b0;
            press <= 1'b0;
            rel   <= 1'b0;
        end else begin
            s1    <= din;
            s2    <= s1;
            press <= 1'b0;
            rel   <= 1'b0;
            if (tick) begin
                // Agreeing with o is a glitch rejection: the count restarts.
                if (s2 == o) begin
                    cnt <= '0;
                end else if (cnt == CNT_W'(STABLE_TICKS - 1)) begin
                    o     <= s2;
                    cnt   <= '0;
                    press <= s2;
                    rel   <= ~s2;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end
endmodule

module debounce_ctrl #(
    parameter int N_CH         = 4,
    parameter int TICK_CYCLES  = 100000,
    parameter int STABLE_TICKS = 10
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N_CH-1:0]     i,
    output logic [N_CH-1:0]     o,
    output logic [N_CH-1:0]     press,
    output logic [N_CH-1:0]     rel,   // release pulse; "release" is a reserved word
    output logic                tick,
    debounce_ctrl_if.master     ev,
    output logic [N_CH-1:0]     ev_overrun
);
    localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int CNT_W = (STABLE_TICKS > 1) ? $clog2(STABLE_TICKS + 1) : 1;
    localparam int PS_W  = $clog2(TICK_CYCLES);

    typedef enum logic {IDLE = 1'b0, OFFER = 1'b1} arb_state_e;

    // Assertion is immediate; deassertion is retimed onto clk.
    logic [1:0] rst_sync;
    logic       rst_n;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rst_sync <= 2'b00;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n = rst_sync[1];

    logic [PS_W-1:0] ps_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                ps_cnt <= '0;
        else if (ps_cnt == PS_W'(TICK_CYCLES - 1)) ps_cnt <= '0;
        else                                       ps_cnt <= ps_cnt + 1'b1;
    end
    assign tick = (ps_cnt == PS_W'(TICK_CYCLES - 1));

    for (genvar k = 0; k < N_CH; k++) begin : g_lane
        debounce_lane #(
            .STABLE_TICKS (STABLE_TICKS),
            .CNT_W        (CNT_W)
        ) u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .din   (i[k]),
            .tick  (tick),
            .o     (o[k]),
            .press (press[k]),
            .rel   (rel[k])
        );
    end

    // First requester at or after base, wrapping; MSB flags a hit.
    function automatic logic [CH_W:0] rr_pick(input logic [N_CH-1:0] req,
                                              input logic [CH_W-1:0] base);
        logic [CH_W:0]   r;
        logic [CH_W-1:0] ix;
        int              idx;
        r = '0;
        for (int j = N_CH - 1; j >= 0; j--) begin
            idx = int'(base) + j;
            if (idx >= N_CH) idx = idx - N_CH;
            ix = CH_W'(idx);
            if (req[ix]) r = {1'b1, ix};
        end
        return r;
    endfunction

    arb_state_e      state, state_nxt;
    logic [N_CH-1:0] pending, pend_nxt, kind, kind_nxt, ovr_nxt, edge_v;
    logic            again, again_nxt, evp_q, evp_nxt;
    logic [CH_W-1:0] ptr, ptr_nxt, ch_q, ch_nxt;
    logic [CH_W:0]   pick;

    assign edge_v = press | rel;

    always_comb begin
        state_nxt = state;
        pend_nxt  = pending;
        kind_nxt  = kind;
        ovr_nxt   = ev_overrun;
        again_nxt = again;
        ptr_nxt   = ptr;
        ch_nxt    = ch_q;
        evp_nxt   = evp_q;
        pick      = rr_pick(pending, ptr);

        for (int k = 0; k < N_CH; k++) begin
            if (edge_v[k]) begin
                kind_nxt[k] = press[k];
                // An edge on the channel being offered is a fresh event,
                // queued behind the frozen offer rather than an overrun.
                if (state == OFFER && ch_q == CH_W'(k)) begin
                    if (again) ovr_nxt[k] = 1'b1;
                    again_nxt = 1'b1;
                end else begin
                    if (pending[k]) ovr_nxt[k] = 1'b1;
                    pend_nxt[k] = 1'b1;
                end
            end
        end

        case (state)
            IDLE: begin
                if (pick[CH_W]) begin
                    ch_nxt    = pick[CH_W-1:0];
                    evp_nxt   = kind_nxt[pick[CH_W-1:0]];
                    state_nxt = OFFER;
                end
            end
            OFFER: begin
                if (ev.ev_ready) begin
                    pend_nxt[ch_q] = again_nxt;
                    again_nxt      = 1'b0;
                    ptr_nxt        = (ch_q == CH_W'(N_CH - 1)) ? '0 : ch_q + 1'b1;
                    state_nxt      = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            pending    <= '0;
            kind       <= '0;
            ev_overrun <= '0;
            again      <= 1'b0;
            ptr        <= '0;
            ch_q       <= '0;
            evp_q      <= 1'b0;
        end else begin
            state      <= state_nxt;
            pending    <= pend_nxt;
            kind       <= kind_nxt;
            ev_overrun <= ovr_nxt;
            again      <= again_nxt;
            ptr        <= ptr_nxt;
            ch_q       <= ch_nxt;
            evp_q      <= evp_nxt;
        end
    end

    assign ev.ev_valid = (state == OFFER);
    assign ev.ev_ch    = ch_q;
    assign ev.ev_press = evp_q;
endmodule
